// File: rtl/rvnoob_regfile_sb.sv
// RV64 integer register file: 2 combinational read ports with write-back bypass, 1 write port,
// and a per-register pending-write scoreboard for RAW hazard detection.
module rvnoob_regfile_sb #(
  parameter int unsigned XLEN   = 64,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  output logic            rs1_busy,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  output logic            rs2_busy,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            set_en,
  input  logic [4:0]      set_addr,
  input  logic            flush,
  output logic [5:0]      busy_cnt,
  output logic [XLEN-1:0] rf_0,  rf_1,  rf_2,  rf_3,  rf_4,  rf_5,  rf_6,  rf_7,
  output logic [XLEN-1:0] rf_8,  rf_9,  rf_10, rf_11, rf_12, rf_13, rf_14, rf_15,
  output logic [XLEN-1:0] rf_16, rf_17, rf_18, rf_19, rf_20, rf_21, rf_22, rf_23,
  output logic [XLEN-1:0] rf_24, rf_25, rf_26, rf_27, rf_28, rf_29, rf_30, rf_31
);

  logic [XLEN-1:0] regs_q [32];
  logic [31:0]     busy_q, busy_d;
  logic            wr_valid;

  assign wr_valid = wen && (waddr != 5'd0);

  // Flush squashes every claim, including one issued this cycle; a claim beats a
  // same-cycle write-back because the new producer supersedes the old one.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_valid) busy_d[waddr] = 1'b0;
      if (set_en)   busy_d[set_addr] = 1'b1;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_valid) regs_q[waddr] <= wdata;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < 32; i++) busy_cnt = busy_cnt + 6'(busy_q[i]);
  end

  always_comb begin
    rdata1   = '0;
    rs1_busy = 1'b0;
    if (raddr1 != 5'd0) begin
      if (BYPASS && wen && (waddr == raddr1)) rdata1 = wdata;
      else                                    rdata1 = regs_q[raddr1];
      rs1_busy = busy_q[raddr1] && !(BYPASS && wen && (waddr == raddr1));
    end
  end

  always_comb begin
    rdata2   = '0;
    rs2_busy = 1'b0;
    if (raddr2 != 5'd0) begin
      if (BYPASS && wen && (waddr == raddr2)) rdata2 = wdata;
      else                                    rdata2 = regs_q[raddr2];
      rs2_busy = busy_q[raddr2] && !(BYPASS && wen && (waddr == raddr2));
    end
  end

  // Architectural view for difftest: stored values only, never bypassed.
  assign rf_0  = regs_q[0];
  assign rf_1  = regs_q[1];
  assign rf_2  = regs_q[2];
  assign rf_3  = regs_q[3];
  assign rf_4  = regs_q[4];
  assign rf_5  = regs_q[5];
  assign rf_6  = regs_q[6];
  assign rf_7  = regs_q[7];
  assign rf_8  = regs_q[8];
  assign rf_9  = regs_q[9];
  assign rf_10 = regs_q[10];
  assign rf_11 = regs_q[11];
  assign rf_12 = regs_q[12];
  assign rf_13 = regs_q[13];
  assign rf_14 = regs_q[14];
  assign rf_15 = regs_q[15];
  assign rf_16 = regs_q[16];
  assign rf_17 = regs_q[17];
  assign rf_18 = regs_q[18];
  assign rf_19 = regs_q[19];
  assign rf_20 = regs_q[20];
  assign rf_21 = regs_q[21];
  assign rf_22 = regs_q[22];
  assign rf_23 = regs_q[23];
  assign rf_24 = regs_q[24];
  assign rf_25 = regs_q[25];
  assign rf_26 = regs_q[26];
  assign rf_27 = regs_q[27];
  assign rf_28 = regs_q[28];
  assign rf_29 = regs_q[29];
  assign rf_30 = regs_q[30];
  assign rf_31 = regs_q[31];

endmodule

// File: tb/tb_rvnoob_regfile_sb.sv
// Self-checking bench for rvnoob_regfile_sb: directed scenarios plus random traffic
// compared against an array-based model of the register file and scoreboard.
module tb_rvnoob_regfile_sb;

  localparam int unsigned XLEN = 64;
  localparam bit BYPASS = 1'b1;

  logic            clock = 1'b0;
  logic            reset;
  logic [4:0]      raddr1, raddr2, waddr, set_addr;
  logic [XLEN-1:0] rdata1, rdata2, wdata;
  logic            rs1_busy, rs2_busy, wen, set_en, flush;
  logic [5:0]      busy_cnt;
  logic [XLEN-1:0] rf [32];

  int checks = 0;
  int failures = 0;

  logic [XLEN-1:0] m_regs [32];
  bit              m_busy [32];

  always #5 clock = ~clock;

  rvnoob_regfile_sb #(.XLEN(XLEN), .BYPASS(BYPASS)) dut (
    .clock(clock), .reset(reset),
    .raddr1(raddr1), .rdata1(rdata1), .rs1_busy(rs1_busy),
    .raddr2(raddr2), .rdata2(rdata2), .rs2_busy(rs2_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .set_en(set_en), .set_addr(set_addr), .flush(flush), .busy_cnt(busy_cnt),
    .rf_0(rf[0]),   .rf_1(rf[1]),   .rf_2(rf[2]),   .rf_3(rf[3]),
    .rf_4(rf[4]),   .rf_5(rf[5]),   .rf_6(rf[6]),   .rf_7(rf[7]),
    .rf_8(rf[8]),   .rf_9(rf[9]),   .rf_10(rf[10]), .rf_11(rf[11]),
    .rf_12(rf[12]), .rf_13(rf[13]), .rf_14(rf[14]), .rf_15(rf[15]),
    .rf_16(rf[16]), .rf_17(rf[17]), .rf_18(rf[18]), .rf_19(rf[19]),
    .rf_20(rf[20]), .rf_21(rf[21]), .rf_22(rf[22]), .rf_23(rf[23]),
    .rf_24(rf[24]), .rf_25(rf[25]), .rf_26(rf[26]), .rf_27(rf[27]),
    .rf_28(rf[28]), .rf_29(rf[29]), .rf_30(rf[30]), .rf_31(rf[31])
  );

  function automatic logic [XLEN-1:0] exp_rd(input logic [4:0] a);
    if (a == 0) return '0;
    if (BYPASS && wen && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(BYPASS && wen && waddr == a);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic idle();
    reset = 0; wen = 0; waddr = 0; wdata = '0; set_en = 0; set_addr = 0; flush = 0;
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (flush) m_busy[i] = 0;
        else if (set_en && set_addr == 5'(i)) m_busy[i] = 1;
        else if (wen && waddr == 5'(i)) m_busy[i] = 0;
      end
      if (wen && waddr != 0) m_regs[waddr] = wdata;
    end
    #2;
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); reset = 0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
      checks += 3;
      if (rdata1 !== '0) begin failures++; $display("FAIL reset_rdata1 a=%0d got=%h exp=0", a, rdata1); end
      if (rdata2 !== '0) begin failures++; $display("FAIL reset_rdata2 a=%0d got=%h exp=0", a, rdata2); end
      if (rf[a] !== '0) begin failures++; $display("FAIL reset_rf a=%0d got=%h exp=0", a, rf[a]); end
    end
    checks++;
    if (busy_cnt !== 6'd0) begin failures++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_write_bypass();
    logic [XLEN-1:0] v = 64'hDEADBEEF_00000001;
    idle(); wen = 1; waddr = 5; wdata = v; raddr1 = 5; #1;
    checks++;
    if (rdata1 !== v) begin failures++; $display("FAIL bypass_rdata1 got=%h exp=%h", rdata1, v); end
    tick(); idle(); #1;
    checks += 2;
    if (rf[5] !== v) begin failures++; $display("FAIL write_rf5 got=%h exp=%h", rf[5], v); end
    if (rdata1 !== v) begin failures++; $display("FAIL write_rdata1 got=%h exp=%h", rdata1, v); end
    wen = 1; waddr = 0; wdata = 64'h1234; raddr1 = 0; #1;
    checks++;
    if (rdata1 !== '0) begin failures++; $display("FAIL x0_bypass got=%h exp=0", rdata1); end
    tick(); idle(); #1;
    checks += 2;
    if (rf[0] !== '0) begin failures++; $display("FAIL x0_rf got=%h exp=0", rf[0]); end
    if (rdata1 !== '0) begin failures++; $display("FAIL x0_rdata1 got=%h exp=0", rdata1); end
  endtask

  task automatic test_claim_release();
    idle(); set_en = 1; set_addr = 7; raddr1 = 7; tick(); idle(); #1;
    checks += 2;
    if (rs1_busy !== 1'b1) begin failures++; $display("FAIL claim_busy got=%b exp=1", rs1_busy); end
    if (busy_cnt !== 6'd1) begin failures++; $display("FAIL claim_cnt got=%0d exp=1", busy_cnt); end
    wen = 1; waddr = 7; wdata = 64'hA5A5; #1;
    checks++;
    if (rs1_busy !== 1'b0) begin failures++; $display("FAIL release_bypass_busy got=%b exp=0", rs1_busy); end
    tick(); idle(); #1;
    checks += 2;
    if (busy_cnt !== 6'd0) begin failures++; $display("FAIL release_cnt got=%0d exp=0", busy_cnt); end
    if (rs1_busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", rs1_busy); end
  endtask

  task automatic test_set_wins();
    logic [XLEN-1:0] v = 64'h0123_4567_89AB_CDEF;
    idle(); set_en = 1; set_addr = 9; tick();
    set_en = 1; set_addr = 9; wen = 1; waddr = 9; wdata = v; tick(); idle(); raddr1 = 9; #1;
    checks += 3;
    if (rs1_busy !== 1'b1) begin failures++; $display("FAIL setwins_busy got=%b exp=1", rs1_busy); end
    if (busy_cnt !== 6'd1) begin failures++; $display("FAIL setwins_cnt got=%0d exp=1", busy_cnt); end
    if (rf[9] !== v) begin failures++; $display("FAIL setwins_rf9 got=%h exp=%h", rf[9], v); end
    wen = 1; waddr = 9; wdata = v; tick(); idle();
  endtask

  task automatic test_fill_flush();
    idle();
    for (int i = 1; i < 32; i++) begin set_en = 1; set_addr = 5'(i); tick(); end
    idle(); #1;
    checks++;
    if (busy_cnt !== 6'd31) begin failures++; $display("FAIL fill_cnt got=%0d exp=31", busy_cnt); end
    flush = 1; set_en = 1; set_addr = 3; tick(); idle(); raddr1 = 3; raddr2 = 31; #1;
    checks += 3;
    if (busy_cnt !== 6'd0) begin failures++; $display("FAIL flush_cnt got=%0d exp=0", busy_cnt); end
    if (rs1_busy !== 1'b0) begin failures++; $display("FAIL flush_busy3 got=%b exp=0", rs1_busy); end
    if (rs2_busy !== 1'b0) begin failures++; $display("FAIL flush_busy31 got=%b exp=0", rs2_busy); end
  endtask

  task automatic test_reset_mid();
    idle(); set_en = 1; set_addr = 10; tick();
    set_en = 1; set_addr = 12; wen = 1; waddr = 10; wdata = 64'h55; tick(); idle(); #1;
    checks += 2;
    if (rf[10] !== 64'h55) begin failures++; $display("FAIL pre_reset_rf10 got=%h exp=55", rf[10]); end
    if (busy_cnt !== 6'd1) begin failures++; $display("FAIL pre_reset_cnt got=%0d exp=1", busy_cnt); end
    reset = 1; wen = 1; waddr = 10; wdata = 64'hFF; set_en = 1; set_addr = 4; tick(); idle(); #1;
    checks += 3;
    if (rf[10] !== '0) begin failures++; $display("FAIL reset_mid_rf10 got=%h exp=0", rf[10]); end
    if (rf[5] !== '0) begin failures++; $display("FAIL reset_mid_rf5 got=%h exp=0", rf[5]); end
    if (busy_cnt !== 6'd0) begin failures++; $display("FAIL reset_mid_cnt got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      wen      = ($urandom_range(0, 1) == 1);
      waddr    = 5'($urandom_range(0, 31));
      wdata    = {$urandom, $urandom};
      set_en   = ($urandom_range(0, 2) != 0);
      set_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2   = ($urandom_range(0, 7) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      #1;
      checks += 5;
      if (rdata1 !== exp_rd(raddr1)) begin
        failures++; $display("FAIL rand_rdata1 n=%0d a=%0d got=%h exp=%h", n, raddr1, rdata1, exp_rd(raddr1));
      end
      if (rdata2 !== exp_rd(raddr2)) begin
        failures++; $display("FAIL rand_rdata2 n=%0d a=%0d got=%h exp=%h", n, raddr2, rdata2, exp_rd(raddr2));
      end
      if (rs1_busy !== exp_busy(raddr1)) begin
        failures++; $display("FAIL rand_rs1_busy n=%0d got=%b exp=%b", n, rs1_busy, exp_busy(raddr1));
      end
      if (rs2_busy !== exp_busy(raddr2)) begin
        failures++; $display("FAIL rand_rs2_busy n=%0d got=%b exp=%b", n, rs2_busy, exp_busy(raddr2));
      end
      if (int'(busy_cnt) != exp_cnt()) begin
        failures++; $display("FAIL rand_busy_cnt n=%0d got=%0d exp=%0d", n, busy_cnt, exp_cnt());
      end
      tick();
    end
    idle(); #1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rf[i] !== m_regs[i]) begin
        failures++; $display("FAIL rand_rf i=%0d got=%h exp=%h", i, rf[i], m_regs[i]);
      end
    end
  endtask

  initial begin
    idle(); raddr1 = 0; raddr2 = 0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    #2;
    test_reset();
    test_write_bypass();
    test_claim_release();
    test_set_wins();
    test_fill_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
